keypad_entry_ctrl: RTL and testbench



---
 rtl/keypad_pkg.sv | 25 ++
 rtl/digit_shift_buf.sv | 62 ++++++
 rtl/keypad_entry_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad entry controller.
//   - command key codes (clear, backspace, enter)
//   - controller state encoding
//   - default number of entry digits
//   - helper classifying a key code as a data key
package keypad_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] KEY_CLEAR = 4'hD;
    localparam logic [3:0] KEY_BACK  = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Codes 0..C are digits; D..F are commands.
    function automatic logic is_data_key(input logic [3:0] k);
        return (k <= 4'hC);
    endfunction

endpackage

// File: rtl/digit_shift_buf.sv
// digit_shift_buf: right-aligned digit buffer with per-digit blank flags.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           empty the buffer (all zero, all blank, count 0)
//   shl, din      shift left and insert din as digit0 (newest)
//   shr           drop digit0, shift the rest right, blank the top digit
//   digits        packed digits, digit i = [4i+3:4i]
//   blank         1 = digit i blank
//   count         number of valid digits
// Priority is clr > shl > shr. The caller guarantees shl is never issued
// when full and shr never when empty.
module digit_shift_buf #(
    parameter int NUM_DIGITS = keypad_pkg::NUM_DIGITS,
    parameter int CW         = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    shl,
    input  logic                    shr,
    input  logic [3:0]              din,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [CW-1:0]           count
);

    localparam int DW = 4 * NUM_DIGITS;

    logic [DW-1:0]         digits_r;
    logic [NUM_DIGITS-1:0] blank_r;
    logic [CW-1:0]         count_r;

    // Buffer contents: clear, insert-left or delete-right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_r <= '0;
            blank_r  <= '1;
            count_r  <= '0;
        end else if (clr) begin
            digits_r <= '0;
            blank_r  <= '1;
            count_r  <= '0;
        end else if (shl) begin
            digits_r <= {digits_r[DW-5:0], din};
            blank_r  <= {blank_r[NUM_DIGITS-2:0], 1'b0};
            count_r  <= count_r + CW'(1);
        end else if (shr) begin
            digits_r <= {4'h0, digits_r[DW-1:4]};
            blank_r  <= {1'b1, blank_r[NUM_DIGITS-1:1]};
            count_r  <= count_r - CW'(1);
        end else begin
            digits_r <= digits_r;
            blank_r  <= blank_r;
            count_r  <= count_r;
        end
    end

    assign digits = digits_r;
    assign blank  = blank_r;
    assign count  = count_r;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad numeric entry sequencer.
// Ports:
//   CLOCK_50, Reset    clock, asynchronous active-high reset
//   keyCode, keyValid  debounced key code and key-held level
//   digits, digitBlank display digits (digit0 newest) and blank flags
//   entryCount         digits currently entered
//   value, valueValid  committed value, held until valueReady is sampled
//   valueReady         consumer accepts value
//   overflow           1-cycle pulse when a data key hits a full buffer
module keypad_entry_ctrl #(
    parameter int NUM_DIGITS     = keypad_pkg::NUM_DIGITS,
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int CNT_W          = 28
) (
    input  logic                              CLOCK_50,
    input  logic                              Reset,
    input  logic [3:0]                        keyCode,
    input  logic                              keyValid,
    output logic [4*NUM_DIGITS-1:0]           digits,
    output logic [NUM_DIGITS-1:0]             digitBlank,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   entryCount,
    output logic [4*NUM_DIGITS-1:0]           value,
    output logic                              valueValid,
    input  logic                              valueReady,
    output logic                              overflow
);

    import keypad_pkg::*;

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    state_t               state_r;
    logic                 last_valid_r;
    logic [CNT_W-1:0]     tmo_cnt_r;
    logic [DW-1:0]        value_r;
    logic                 value_valid_r;
    logic                 overflow_r;

    logic                 press_s;
    logic                 is_data_s;
    logic                 full_s;
    logic                 tmo_hit_s;
    logic                 shl_s;
    logic                 shr_s;
    logic                 clr_s;
    logic [DW-1:0]        buf_digits_s;
    logic [NUM_DIGITS-1:0] buf_blank_s;
    logic [CW-1:0]        buf_count_s;

    // Blank positions contribute zero to a committed value.
    function automatic logic [DW-1:0] mask_blank(input logic [DW-1:0] d,
                                                 input logic [NUM_DIGITS-1:0] b);
        logic [DW-1:0] m;
        m = d;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[i]) begin
                m[4*i +: 4] = 4'h0;
            end else begin
                m[4*i +: 4] = d[4*i +: 4];
            end
        end
        return m;
    endfunction

    assign press_s   = keyValid & ~last_valid_r;
    assign is_data_s = is_data_key(keyCode);
    assign full_s    = (buf_count_s == CW'(NUM_DIGITS));
    // Comparing against TIMEOUT_CYCLES-2 clears on the edge the count would reach TIMEOUT_CYCLES-1.
    assign tmo_hit_s = (state_r == ENTRY) && !press_s &&
                       (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 2));

    // Buffer control decode from state and the current press.
    always_comb begin
        shl_s = 1'b0;
        shr_s = 1'b0;
        clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (press_s && is_data_s) begin
                    shl_s = 1'b1;
                end else begin
                    shl_s = 1'b0;
                end
            end
            ENTRY: begin
                if (press_s) begin
                    if (is_data_s) begin
                        shl_s = !full_s;
                    end else if (keyCode == KEY_BACK) begin
                        shr_s = 1'b1;
                    end else begin
                        clr_s = 1'b1;   // clear or enter both empty the buffer
                    end
                end else begin
                    clr_s = tmo_hit_s;
                end
            end
            COMMIT: begin
                clr_s = 1'b0;
            end
            default: begin
                clr_s = 1'b1;
            end
        endcase
    end

    // Controller state, press edge detect, timeout and commit handshake.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_r       <= IDLE;
            last_valid_r  <= 1'b0;
            tmo_cnt_r     <= '0;
            value_r       <= '0;
            value_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            last_valid_r <= keyValid;
            overflow_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    tmo_cnt_r <= '0;
                    if (press_s && is_data_s) begin
                        state_r <= ENTRY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ENTRY: begin
                    if (press_s) begin
                        tmo_cnt_r <= '0;
                        if (is_data_s) begin
                            overflow_r <= full_s;
                        end else if (keyCode == KEY_CLEAR) begin
                            state_r <= IDLE;
                        end else if (keyCode == KEY_BACK) begin
                            if (buf_count_s == CW'(1)) begin
                                state_r <= IDLE;
                            end else begin
                                state_r <= ENTRY;
                            end
                        end else begin
                            value_r       <= mask_blank(buf_digits_s, buf_blank_s);
                            value_valid_r <= 1'b1;
                            state_r       <= COMMIT;
                        end
                    end else if (tmo_hit_s) begin
                        tmo_cnt_r <= '0;
                        state_r   <= IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    tmo_cnt_r <= '0;
                    // Presses here are dropped, including one coinciding with ready.
                    if (valueReady) begin
                        value_valid_r <= 1'b0;
                        state_r       <= IDLE;
                    end else begin
                        state_r <= COMMIT;
                    end
                end
                default: begin
                    tmo_cnt_r     <= '0;
                    value_valid_r <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    digit_shift_buf #(
        .NUM_DIGITS (NUM_DIGITS),
        .CW         (CW)
    ) u_buf (
        .clk    (CLOCK_50),
        .rst    (Reset),
        .clr    (clr_s),
        .shl    (shl_s),
        .shr    (shr_s),
        .din    (keyCode),
        .digits (buf_digits_s),
        .blank  (buf_blank_s),
        .count  (buf_count_s)
    );

    assign digits     = buf_digits_s;
    assign digitBlank = buf_blank_s;
    assign entryCount = buf_count_s;
    assign value      = value_r;
    assign valueValid = value_valid_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed stimulus for keypad_entry_ctrl with a
// queue-based reference model compared on every falling clock edge, plus
// hand-computed literal expectations at key points.
module tb_keypad_entry_ctrl;

    localparam int TO = 20;

    logic        CLOCK_50 = 1'b0;
    logic        Reset    = 1'b1;
    logic [3:0]  keyCode  = 4'h0;
    logic        keyValid = 1'b0;
    logic        valueReady = 1'b0;
    logic [23:0] digits;
    logic [5:0]  digitBlank;
    logic [2:0]  entryCount;
    logic [23:0] value;
    logic        valueValid;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    keypad_entry_ctrl #(
        .NUM_DIGITS     (6),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (28)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .Reset      (Reset),
        .keyCode    (keyCode),
        .keyValid   (keyValid),
        .digits     (digits),
        .digitBlank (digitBlank),
        .entryCount (entryCount),
        .value      (value),
        .valueValid (valueValid),
        .valueReady (valueReady),
        .overflow   (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entered digits as a queue, newest at index 0.
    int          mq[$];
    bit          m_last   = 1'b0;
    bit          m_commit = 1'b0;
    logic [23:0] m_val    = 24'h0;
    bit          m_ovf    = 1'b0;
    int          m_idle   = 0;

    function automatic logic [23:0] m_digits();
        logic [23:0] d;
        d = 24'h0;
        for (int i = 0; i < mq.size(); i++) d = d | (24'(mq[i]) << (4 * i));
        return d;
    endfunction

    function automatic logic [5:0] m_blank();
        logic [5:0] b;
        b = 6'b111111;
        for (int i = 0; i < mq.size(); i++) b[i] = 1'b0;
        return b;
    endfunction

    initial begin
        forever begin
            @(posedge CLOCK_50 or posedge Reset);
            if (Reset) begin
                mq.delete();
                m_last = 1'b0; m_commit = 1'b0; m_val = 24'h0; m_ovf = 1'b0; m_idle = 0;
            end else begin
                bit p;
                p = keyValid && !m_last;
                m_last = keyValid;
                m_ovf = 1'b0;
                if (m_commit) begin
                    if (valueReady) m_commit = 1'b0;
                end else if (p) begin
                    m_idle = 0;
                    if (keyCode <= 4'hC) begin
                        if (mq.size() < 6) mq.push_front(int'(keyCode));
                        else m_ovf = 1'b1;
                    end else if (keyCode == 4'hD) begin
                        mq.delete();
                    end else if (keyCode == 4'hE) begin
                        if (mq.size() > 0) mq.delete(0);
                    end else begin
                        if (mq.size() > 0) begin
                            m_val = m_digits();
                            m_commit = 1'b1;
                            mq.delete();
                        end
                    end
                end else if (mq.size() > 0) begin
                    m_idle++;
                    if (m_idle == TO - 1) begin
                        mq.delete();
                        m_idle = 0;
                    end
                end
                if (mq.size() == 0) m_idle = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            chk("m_digits", 32'(digits), 32'(m_digits()));
            chk("m_blank", 32'(digitBlank), 32'(m_blank()));
            chk("m_count", 32'(entryCount), 32'(mq.size()));
            chk("m_value", 32'(value), 32'(m_val));
            chk("m_valid", 32'(valueValid), 32'(m_commit));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge CLOCK_50);
        keyCode  = k;
        keyValid = 1'b1;
        @(negedge CLOCK_50);
        keyValid = 1'b0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLOCK_50);
        chk("rst_blank", 32'(digitBlank), 32'h3F);
        chk("rst_count", 32'(entryCount), 32'h0);
        chk("rst_valid", 32'(valueValid), 32'h0);
        Reset = 1'b0;

        // 1,2,3 with latency check on the third key
        press(4'h1);
        press(4'h2);
        @(negedge CLOCK_50);
        keyCode = 4'h3; keyValid = 1'b1;
        #4;
        chk("lat_before", 32'(entryCount), 32'h2);
        @(negedge CLOCK_50);
        chk("lat_after", 32'(entryCount), 32'h3);
        keyValid = 1'b0;
        @(negedge CLOCK_50);
        chk("d123", 32'(digits[11:0]), 32'h123);
        chk("b123", 32'(digitBlank), 32'h38);

        // Fill to six, then overflow
        press(4'hD);
        for (int i = 1; i <= 6; i++) press(4'(i));
        @(negedge CLOCK_50);
        keyCode = 4'h7; keyValid = 1'b1;
        @(negedge CLOCK_50);
        chk("ovf_hi", 32'(overflow), 32'h1);
        keyValid = 1'b0;
        @(negedge CLOCK_50);
        chk("ovf_lo", 32'(overflow), 32'h0);
        chk("full_digits", 32'(digits), 32'h123456);
        chk("full_count", 32'(entryCount), 32'h6);

        // Backspace and commit held off by valueReady
        press(4'hD);
        press(4'h4);
        press(4'h5);
        press(4'hE);
        chk("bs_digit", 32'(digits[3:0]), 32'h4);
        chk("bs_blank", 32'(digitBlank), 32'h3E);
        press(4'hF);
        chk("cm_value", 32'(value), 32'h000004);
        chk("cm_valid", 32'(valueValid), 32'h1);
        chk("cm_blank", 32'(digitBlank), 32'h3F);
        repeat (100) @(negedge CLOCK_50);
        chk("cm_hold", 32'(valueValid), 32'h1);
        valueReady = 1'b1;
        @(negedge CLOCK_50);
        chk("cm_done", 32'(valueValid), 32'h0);
        valueReady = 1'b0;
        press(4'h5);
        chk("after_cm", 32'(entryCount), 32'h1);
        press(4'hD);

        // Press coinciding with ready is dropped
        press(4'h2);
        press(4'hF);
        @(negedge CLOCK_50);
        keyCode = 4'h9; keyValid = 1'b1; valueReady = 1'b1;
        @(negedge CLOCK_50);
        chk("coin_valid", 32'(valueValid), 32'h0);
        chk("coin_blank", 32'(digitBlank), 32'h3F);
        keyValid = 1'b0; valueReady = 1'b0;
        @(negedge CLOCK_50);
        chk("coin_count", 32'(entryCount), 32'h0);

        // Idle timeout after TO-1 idle cycles
        press(4'hA);
        repeat (17) @(negedge CLOCK_50);
        chk("tmo_18", 32'(entryCount), 32'h1);
        @(negedge CLOCK_50);
        chk("tmo_19", 32'(entryCount), 32'h0);
        chk("tmo_blank", 32'(digitBlank), 32'h3F);
        press(4'hF);
        chk("idle_enter", 32'(valueValid), 32'h0);

        // Asynchronous reset mid-ENTRY
        press(4'h3);
        @(posedge CLOCK_50);
        #2 Reset = 1'b1;
        #1;
        chk("ar_entry_cnt", 32'(entryCount), 32'h0);
        chk("ar_entry_blk", 32'(digitBlank), 32'h3F);
        @(negedge CLOCK_50);
        Reset = 1'b0;

        // Asynchronous reset mid-COMMIT, key held through release
        press(4'h5);
        press(4'hF);
        chk("pre_ar_valid", 32'(valueValid), 32'h1);
        @(posedge CLOCK_50);
        #2 Reset = 1'b1;
        #1;
        chk("ar_cm_valid", 32'(valueValid), 32'h0);
        chk("ar_cm_value", 32'(value), 32'h0);
        keyCode = 4'h7; keyValid = 1'b1;
        @(negedge CLOCK_50);
        Reset = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        chk("held_count", 32'(entryCount), 32'h1);
        chk("held_digit", 32'(digits), 32'h7);
        keyValid = 1'b0;
        @(negedge CLOCK_50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
